// File: rtl/alu_issue_arb_pkg.sv
// rtl/alu_issue_arb_pkg.sv - shared types and constants for the ALU issue arbiter
package alu_issue_arb_pkg;

  typedef enum logic {
    ARB_SRC0 = 1'b0,
    ARB_SRC1 = 1'b1
  } alu_arb_src_e;

  localparam int ArbStarveCntW = 4;

endpackage

// File: rtl/alu_issue_arb_if.sv
// rtl/alu_issue_arb_if.sv - requester and ALU-side handshake bundle for the issue arbiter
interface alu_issue_arb_if
  import alu_issue_arb_pkg::*;
#(
  parameter int PayloadW = 96
);

  logic                req0_valid_i;
  logic [PayloadW-1:0] req0_data_i;
  logic                req0_rdy_o;
  logic                req1_valid_i;
  logic [PayloadW-1:0] req1_data_i;
  logic                req1_rdy_o;
  logic                alupl_rdy_i;
  logic                alu_valid_o;
  logic [PayloadW-1:0] alu_data_o;
  alu_arb_src_e        alu_src_o;

  modport slave (
    input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i, alupl_rdy_i,
    output req0_rdy_o, req1_rdy_o, alu_valid_o, alu_data_o, alu_src_o
  );

  modport master (
    output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i, alupl_rdy_i,
    input  req0_rdy_o, req1_rdy_o, alu_valid_o, alu_data_o, alu_src_o
  );

endinterface

// File: rtl/alu_issue_arb_outreg.sv
// rtl/alu_issue_arb_outreg.sv - one-entry valid/ready output register toward the ALU pipeline
module alu_issue_arb_outreg
  import alu_issue_arb_pkg::*;
#(
  parameter int PayloadW = 96
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_flush,
  input  logic                i_load,
  input  logic [PayloadW-1:0] i_data,
  input  alu_arb_src_e        i_src,
  input  logic                i_alupl_rdy,
  output logic                o_can_load,
  output logic                o_valid,
  output logic [PayloadW-1:0] o_data,
  output alu_arb_src_e        o_src
);

  logic                r_valid;
  logic [PayloadW-1:0] r_data;
  alu_arb_src_e        r_src;

  // Consume and refill in the same cycle, so a held entry never costs a bubble.
  assign o_can_load = ~r_valid | i_alupl_rdy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= ARB_SRC0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (o_can_load) begin
      r_valid <= i_load;
      if (i_load) begin
        r_data <= i_data;
        r_src  <= i_src;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_src   = r_src;

endmodule

// File: rtl/alu_issue_arb.sv
// rtl/alu_issue_arb.sv - two-slot ALU issue arbiter, slot 0 priority with slot 1 anti-starvation
// Optional transfer/stall counters enabled by ALU_ISSUE_ARB_PERF_EN.
module alu_issue_arb
  import alu_issue_arb_pkg::*;
#(
  parameter int PayloadW  = 96,
  parameter int StarveMax = 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  alu_issue_arb_if.slave bus,
  output logic [31:0]    perf_grant0_o,
  output logic [31:0]    perf_grant1_o,
  output logic [31:0]    perf_stall_o
);

  localparam logic [ArbStarveCntW-1:0] StarveMaxC = ArbStarveCntW'(StarveMax);

  logic [ArbStarveCntW-1:0] r_starve_cnt;
  logic                     w_can_load;
  logic                     w_out_valid;
  logic                     w_force1;
  logic                     w_grant0;
  logic                     w_grant1;
  logic                     w_xfer0;
  logic                     w_xfer1;
  logic [PayloadW-1:0]      w_load_data;
  alu_arb_src_e             w_load_src;

  assign w_force1 = (r_starve_cnt == StarveMaxC);
  assign w_grant1 = bus.req1_valid_i & (~bus.req0_valid_i | w_force1);
  assign w_grant0 = bus.req0_valid_i & ~w_grant1;

  assign bus.req0_rdy_o = w_grant0 & w_can_load & ~flush_i;
  assign bus.req1_rdy_o = w_grant1 & w_can_load & ~flush_i;
  assign w_xfer0        = bus.req0_valid_i & bus.req0_rdy_o;
  assign w_xfer1        = bus.req1_valid_i & bus.req1_rdy_o;

  assign w_load_data = w_xfer1 ? bus.req1_data_i : bus.req0_data_i;
  assign w_load_src  = w_xfer1 ? ARB_SRC1 : ARB_SRC0;

  // Counts slot-0 wins that slot 1 sat through; saturation is what forces slot 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve_cnt <= '0;
    end else if (flush_i || w_xfer1) begin
      r_starve_cnt <= '0;
    end else if (w_xfer0 && bus.req1_valid_i && !w_force1) begin
      r_starve_cnt <= r_starve_cnt + ArbStarveCntW'(1);
    end
  end

  alu_issue_arb_outreg #(
    .PayloadW(PayloadW)
  ) u_outreg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_flush    (flush_i),
    .i_load     (w_xfer0 | w_xfer1),
    .i_data     (w_load_data),
    .i_src      (w_load_src),
    .i_alupl_rdy(bus.alupl_rdy_i),
    .o_can_load (w_can_load),
    .o_valid    (w_out_valid),
    .o_data     (bus.alu_data_o),
    .o_src      (bus.alu_src_o)
  );

  assign bus.alu_valid_o = w_out_valid;

`ifdef ALU_ISSUE_ARB_PERF_EN
  logic [31:0] r_perf_grant0;
  logic [31:0] r_perf_grant1;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_xfer0) r_perf_grant0 <= r_perf_grant0 + 32'd1;
      if (w_xfer1) r_perf_grant1 <= r_perf_grant1 + 32'd1;
      if (w_out_valid && !bus.alupl_rdy_i) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_grant0_o = r_perf_grant0;
  assign perf_grant1_o = r_perf_grant1;
  assign perf_stall_o  = r_perf_stall;
`else
  assign perf_grant0_o = 32'h0;
  assign perf_grant1_o = 32'h0;
  assign perf_stall_o  = 32'h0;
`endif

  a_rdy0_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.req0_rdy_o |-> bus.req0_valid_i);
  a_rdy1_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.req1_rdy_o |-> bus.req1_valid_i);
  a_single_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.req0_rdy_o && bus.req1_rdy_o));
  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_out_valid && !bus.alupl_rdy_i && !flush_i) |=> $stable(bus.alu_data_o));

endmodule

// File: tb/tb_alu_issue_arb.sv
// tb/tb_alu_issue_arb.sv - directed self-checking bench for alu_issue_arb
module tb_alu_issue_arb;
  import alu_issue_arb_pkg::*;

  localparam int PW = 96;
`ifdef ALU_ISSUE_ARB_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] perf_grant0_o;
  logic [31:0] perf_grant1_o;
  logic [31:0] perf_stall_o;

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue_arb_if #(.PayloadW(PW)) bus ();

  alu_issue_arb #(
    .PayloadW (PW),
    .StarveMax(3)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .bus          (bus.slave),
    .perf_grant0_o(perf_grant0_o),
    .perf_grant1_o(perf_grant1_o),
    .perf_stall_o (perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [PW-1:0] d,
                           input logic s, input int cnt);
    check({tag, ".valid"}, bus.alu_valid_o, v);
    check({tag, ".data"}, bus.alu_data_o, d);
    check({tag, ".src"}, bus.alu_src_o, s);
    check({tag, ".starve"}, dut.r_starve_cnt, cnt);
  endtask

  task automatic check_perf(input string tag, input int g0, input int g1, input int st);
    check({tag, ".pg0"}, perf_grant0_o, PerfOn ? g0 : 0);
    check({tag, ".pg1"}, perf_grant1_o, PerfOn ? g1 : 0);
    check({tag, ".pst"}, perf_stall_o, PerfOn ? st : 0);
  endtask

  initial begin
    bit exp_g1 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int exp_cnt[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int g0 = 0;
    int g1 = 0;
    logic [PW-1:0] d_x;
    logic [PW-1:0] d_y;

    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    bus.req0_data_i  = '0;
    bus.req1_data_i  = '0;
    bus.alupl_rdy_i  = 1'b1;

    #1;
    check_out("reset", 1'b0, '0, 1'b0, 0);
    check_perf("reset", 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    tick();

    // Scenario 1: slot 0 alone, back to back.
    bus.req0_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req0_data_i = PW'(96'h100 + i);
      #1;
      check("s1.rdy0", bus.req0_rdy_o, 1'b1);
      check("s1.rdy1", bus.req1_rdy_o, 1'b0);
      tick();
      check_out("s1", 1'b1, PW'(96'h100 + i), 1'b0, 0);
    end
    bus.req0_valid_i = 1'b0;
    tick();
    check("s1.idle", bus.alu_valid_o, 1'b0);
    g0 = 5;
    check_perf("s1", g0, g1, 0);

    // Scenario 2: both valid, starvation forcing every fourth grant.
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.req0_data_i = PW'(96'hA00 + i);
      bus.req1_data_i = PW'(96'hB00 + i);
      #1;
      check("s2.rdy0", bus.req0_rdy_o, !exp_g1[i]);
      check("s2.rdy1", bus.req1_rdy_o, exp_g1[i]);
      tick();
      if (exp_g1[i]) g1++;
      else g0++;
      check_out("s2", 1'b1, exp_g1[i] ? PW'(96'hB00 + i) : PW'(96'hA00 + i),
                exp_g1[i], exp_cnt[i]);
      check_perf("s2", g0, g1, 0);
    end

    // Scenario 3: ALU stalls for 4 cycles, then consume and refill together.
    d_x = {32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_00C3};
    d_y = {32'hFEED_F00D, 32'h8765_4321, 32'h0000_00C4};
    bus.req1_valid_i = 1'b0;
    bus.req0_data_i  = d_x;
    tick();
    g0++;
    check_out("s3.load", 1'b1, d_x, 1'b0, 0);
    bus.alupl_rdy_i  = 1'b0;
    bus.req1_valid_i = 1'b1;
    bus.req0_data_i  = d_y;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("s3.rdy0", bus.req0_rdy_o, 1'b0);
      check("s3.rdy1", bus.req1_rdy_o, 1'b0);
      tick();
      check_out("s3.hold", 1'b1, d_x, 1'b0, 0);
    end
    check_perf("s3", g0, g1, 4);
    bus.alupl_rdy_i = 1'b1;
    #1;
    check("s3.rdy0_rel", bus.req0_rdy_o, 1'b1);
    tick();
    g0++;
    check_out("s3.refill", 1'b1, d_y, 1'b0, 1);

    // Scenario 4: flush with a held output and both requests valid.
    flush_i = 1'b1;
    #1;
    check("s4.rdy0", bus.req0_rdy_o, 1'b0);
    check("s4.rdy1", bus.req1_rdy_o, 1'b0);
    tick();
    flush_i = 1'b0;
    check("s4.valid", bus.alu_valid_o, 1'b0);
    check("s4.starve", dut.r_starve_cnt, 0);
    check_perf("s4", g0, g1, 4);

    // Scenario 5: async reset mid-stream with counter at 2.
    bus.req0_data_i = PW'(96'hC01);
    tick();
    bus.req0_data_i = PW'(96'hC02);
    tick();
    check_out("s5.pre", 1'b1, PW'(96'hC02), 1'b0, 2);
    #2 rst_ni = 1'b0;
    #1;
    check_out("s5.rst", 1'b0, '0, 1'b0, 0);
    check_perf("s5.rst", 0, 0, 0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    bus.req0_data_i = PW'(96'hC03);
    #1;
    check("s5.rdy0", bus.req0_rdy_o, 1'b1);
    check("s5.rdy1", bus.req1_rdy_o, 1'b0);
    tick();
    check_out("s5.post", 1'b1, PW'(96'hC03), 1'b0, 1);

    // Slot 1 alone wins immediately and clears the counter.
    bus.req0_valid_i = 1'b0;
    bus.req1_data_i  = PW'(96'hD01);
    #1;
    check("s6.rdy1", bus.req1_rdy_o, 1'b1);
    tick();
    check_out("s6", 1'b1, PW'(96'hD01), 1'b1, 0);
    check_perf("s6", 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
